// File: rtl/arb_pkg.sv
// Shared definitions for the four-requester round-robin grant arbiter.
package arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Round-robin pick: first set request bit scanning ptr, ptr+1, ptr+2, ptr+3.
    // Scanning downward and overwriting leaves the lowest offset as the winner.
    // The result is meaningless when req is all zero; callers check |req first.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                input logic [ID_W-1:0]    ptr);
        logic [ID_W-1:0] idx;
        logic [ID_W-1:0] pick;
        pick = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ptr + ID_W'(k);
            if (req[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/twoxfourdec.sv
// Enabled 2-to-4 one-hot decoder; all outputs low when En is low.
module twoxfourdec (
    input  logic       En,
    input  logic [1:0] Inp,
    output logic [3:0] Outp
);

    // One-hot decode of Inp, gated by En.
    always_comb begin
        // NOTE: assigning a default before any conditional keeps every path
        // driven, so no latch is inferred for a combinational output.
        Outp = 4'b0000;
        if (En) begin
            Outp[Inp] = 1'b1;
        end
    end

endmodule

// File: rtl/dec_grant_arbiter.sv
// Four-requester round-robin arbiter with a bounded hold time per owner and a
// one-cycle turnaround gap between grants. Grants are fully registered: the
// grant vector is a decode of the owner/enable registers, so there is no
// combinational path from Req to Gnt.
module dec_grant_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [3:0] Req,
    output logic [3:0] Gnt,
    output logic [1:0] Gnt_Id,
    output logic       Gnt_Vld,
    output logic       Busy
);

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    state_t          state;
    logic [ID_W-1:0] owner;
    logic            gnt_en;
    logic [ID_W-1:0] ptr;
    logic [3:0]      hold_cnt;

    logic            owner_req;
    logic            hold_done;

    assign owner_req = Req[owner];
    assign hold_done = (hold_cnt == HOLD_MAX);

    // Arbitration FSM: pick a winner in IDLE/RELEASE, hold it in GRANT until
    // it drops its request or reaches MAX_HOLD, then force one idle cycle.
    always_ff @(posedge Clk) begin
        // NOTE: state registers use non-blocking assignments so every register
        // in this block sees the pre-edge values of the others.
        if (Rst) begin
            state    <= IDLE;
            owner    <= '0;
            gnt_en   <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE, RELEASE: begin
                    if (|Req) begin
                        owner    <= rr_pick(Req, ptr);
                        gnt_en   <= 1'b1;
                        hold_cnt <= 4'd1;
                        state    <= GRANT;
                    end else begin
                        gnt_en   <= 1'b0;
                        state    <= IDLE;
                    end
                end
                GRANT: begin
                    // Other requesters are ignored here: no preemption.
                    if (!owner_req || hold_done) begin
                        gnt_en <= 1'b0;
                        ptr    <= owner + 2'd1;
                        state  <= RELEASE;
                    end else if (hold_cnt < HOLD_MAX) begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end
                default: begin
                    gnt_en <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Grant vector is the decoded owner register, gated by the enable register.
    twoxfourdec u_dec (
        .En   (gnt_en),
        .Inp  (owner),
        .Outp (Gnt)
    );

    assign Gnt_Vld = |Gnt;
    assign Gnt_Id  = owner & {ID_W{gnt_en}};
    assign Busy    = (state == GRANT) || (state == RELEASE);

endmodule

// File: tb/tb_dec_grant_arbiter.sv
// Scoreboard bench for dec_grant_arbiter. Two instances (MAX_HOLD = 8 and 1)
// share stimulus; a transaction-level model predicts each post-edge output.
module tb_dec_grant_arbiter;

    localparam int HOLD_A = 8;
    localparam int HOLD_B = 1;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] id;
        logic       vld;
        logic       busy;
    } obs_t;

    logic       Clk;
    logic       Rst;
    logic [3:0] Req;

    logic [3:0] gnt_a, gnt_b;
    logic [1:0] id_a, id_b;
    logic       vld_a, vld_b;
    logic       busy_a, busy_b;

    int vectors;
    int miscompares;

    obs_t q_a[$];
    obs_t q_b[$];

    // Model state per instance: current owner (-1 = none), cycles granted so
    // far, whether the bus is in its turnaround cycle, and next start point.
    int m_owner[2];
    int m_held[2];
    bit m_gap[2];
    int m_ptr[2];

    dec_grant_arbiter #(.MAX_HOLD(HOLD_A)) u_dut_a (
        .Clk     (Clk),
        .Rst     (Rst),
        .Req     (Req),
        .Gnt     (gnt_a),
        .Gnt_Id  (id_a),
        .Gnt_Vld (vld_a),
        .Busy    (busy_a)
    );

    dec_grant_arbiter #(.MAX_HOLD(HOLD_B)) u_dut_b (
        .Clk     (Clk),
        .Rst     (Rst),
        .Req     (Req),
        .Gnt     (gnt_b),
        .Gnt_Id  (id_b),
        .Gnt_Vld (vld_b),
        .Busy    (busy_b)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = -1;
            m_held[d]  = 0;
            m_gap[d]   = 1'b0;
            m_ptr[d]   = 0;
        end
    endfunction

    // Advance the model by one clock edge and return what the outputs show after it.
    function automatic obs_t model_step(input int d, input logic [3:0] req, input logic rst);
        obs_t o;
        int   lim;
        lim = (d == 0) ? HOLD_A : HOLD_B;
        if (rst) begin
            m_owner[d] = -1;
            m_held[d]  = 0;
            m_gap[d]   = 1'b0;
            m_ptr[d]   = 0;
        end else if (m_owner[d] >= 0) begin
            if (!req[m_owner[d]] || m_held[d] >= lim) begin
                m_ptr[d]   = (m_owner[d] + 1) % 4;
                m_owner[d] = -1;
                m_gap[d]   = 1'b1;
            end else begin
                m_held[d]++;
            end
        end else begin
            m_gap[d] = 1'b0;
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (m_ptr[d] + k) % 4;
                if (req[i]) begin
                    m_owner[d] = i;
                    m_held[d]  = 1;
                    break;
                end
            end
        end
        o.gnt  = (m_owner[d] >= 0) ? 4'(1 << m_owner[d]) : 4'b0000;
        o.id   = (m_owner[d] >= 0) ? 2'(m_owner[d]) : 2'd0;
        o.vld  = (m_owner[d] >= 0);
        o.busy = (m_owner[d] >= 0) || m_gap[d];
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got gnt=%b id=%0d vld=%b busy=%b, expected gnt=%b id=%0d vld=%b busy=%b",
                     name, $time, act.gnt, act.id, act.vld, act.busy,
                     exp.gnt, exp.id, exp.vld, exp.busy);
        end
    endtask

    task automatic check_inv(input string name, input obs_t act);
        logic ok;
        vectors++;
        ok = $onehot0(act.gnt) && (act.vld == (|act.gnt)) &&
             (act.vld ? (act.gnt == (4'b0001 << act.id)) : (act.id == 2'd0));
        if (ok !== 1'b1) begin
            miscompares++;
            $display("FAIL %s @%0t: inconsistent outputs gnt=%b id=%0d vld=%b",
                     name, $time, act.gnt, act.id, act.vld);
        end
    endtask

    // One clock of stimulus: drive on the falling edge, predict at the rising edge.
    task automatic cycle(input logic [3:0] req, input logic rst);
        @(negedge Clk);
        Req = req;
        Rst = rst;
        @(posedge Clk);
        q_a.push_back(model_step(0, req, rst));
        q_b.push_back(model_step(1, req, rst));
    endtask

    task automatic hold(input logic [3:0] req, input int n);
        for (int i = 0; i < n; i++) begin
            cycle(req, 1'b0);
        end
    endtask

    // Monitor: on each falling edge compare whatever the DUTs present with the
    // oldest prediction.
    initial begin
        obs_t act;
        forever begin
            @(negedge Clk);
            if (q_a.size() > 0) begin
                act = '{gnt: gnt_a, id: id_a, vld: vld_a, busy: busy_a};
                check("hold8", act, q_a.pop_front());
                check_inv("hold8_onehot", act);
            end
            if (q_b.size() > 0) begin
                act = '{gnt: gnt_b, id: id_b, vld: vld_b, busy: busy_b};
                check("hold1", act, q_b.pop_front());
                check_inv("hold1_onehot", act);
            end
        end
    end

    initial begin
        logic [3:0] r;
        int         len;
        vectors     = 0;
        miscompares = 0;
        model_reset();
        Rst = 1'b1;
        Req = 4'b0000;

        // Reset state, including requests present during reset.
        cycle(4'b0000, 1'b1);
        cycle(4'b1111, 1'b1);
        cycle(4'b0000, 1'b0);

        // Single requester for three cycles, then release back to idle.
        hold(4'b0010, 3);
        hold(4'b0000, 3);

        // Everyone requesting: full rotation with hold limit and turnaround.
        hold(4'b1111, 50);
        hold(4'b0000, 2);

        // Drive ptr to 3 via requester 2, then check wrap-around 3 -> 0.
        cycle(4'b0000, 1'b1);
        hold(4'b0100, 2);
        hold(4'b0000, 2);
        hold(4'b1001, 14);
        hold(4'b0000, 2);

        // No preemption: requester 1 owns, requester 2 joins.
        cycle(4'b0000, 1'b1);
        hold(4'b0010, 2);
        hold(4'b0110, 12);
        hold(4'b0000, 2);

        // Reset pulse in the middle of a grant.
        hold(4'b0100, 3);
        cycle(4'b0100, 1'b1);
        hold(4'b0100, 4);
        hold(4'b0000, 2);

        // Randomized traffic: patterns held a random number of cycles,
        // occasional bit flips and rare resets.
        for (int n = 0; n < 300; n++) begin
            r   = 4'($urandom_range(0, 15));
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    r = r ^ 4'(1 << $urandom_range(0, 3));
                end
                cycle(r, ($urandom_range(0, 199) == 0));
            end
        end
        hold(4'b0000, 2);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 5 && (q_a.size() > 0 || q_b.size() > 0); i++) begin
            @(negedge Clk);
        end
        @(posedge Clk);
        if (q_a.size() > 0 || q_b.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d/%0d predictions left unchecked, expected 0", q_a.size(), q_b.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
